// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: arbitrates single transfers and sequences SETUP/ACCESS.
// Optional macro APB_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT_CYCLES wait cycles.
module apb_master_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state;
  logic                    last_grant;
  logic                    any_c;
  logic                    grant_c;
  logic [ADDR_WIDTH-1:0]   sel_addr_c;
  logic                    sel_write_c;
  logic [DATA_WIDTH-1:0]   sel_wdata_c;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  logic unused_timeout_c;
  assign unused_timeout_c = (TIMEOUT_CYCLES != 0);
`endif

  // Round-robin pick: prefer the requester not granted last, else whichever is valid
  always_comb begin
    any_c       = |req_valid;
    grant_c     = req_valid[~last_grant] ? ~last_grant : last_grant;
    sel_addr_c  = grant_c ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]  : req_addr[0 +: ADDR_WIDTH];
    sel_write_c = grant_c ? req_write[1]                        : req_write[0];
    sel_wdata_c = grant_c ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
    req_ready   = '0;
    if (state == IDLE && any_c) req_ready[grant_c] = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_c) begin
            state      <= SETUP;
            PSEL       <= 1'b1;
            last_grant <= grant_c;
            PADDR      <= sel_addr_c;
            PWRITE     <= sel_write_c;
            PWDATA     <= sel_wdata_c;
          end else begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_valid <= last_grant ? 2'b10 : 2'b01;
            rsp_err   <= PSLVERR;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
          end
`ifdef APB_TIMEOUT_EN
          // Slave never answered: abort with an error response
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_valid <= last_grant ? 2'b10 : 2'b01;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed cases plus randomized transfers
// checked against a transaction-level round-robin/response model.
module tb_apb_master_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, PWDATA, PRDATA;
  logic          rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;

  apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model state
  logic          m_last;
  logic          pend;
  logic          pend_g;
  logic          pend_err;
  logic [DW-1:0] pend_rdata;
  logic          hold_err;
  logic [DW-1:0] hold_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] oh(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // Checks the response (or its absence) visible in the current IDLE cycle
  task automatic check_rsp();
    if (pend) begin
      check("rsp_valid", 64'(rsp_valid), 64'(oh(pend_g)));
      check("rsp_err",   64'(rsp_err),   64'(pend_err));
      check("rsp_rdata", 64'(rsp_rdata), 64'(pend_rdata));
      hold_err   = pend_err;
      hold_rdata = pend_rdata;
      pend       = 1'b0;
    end else begin
      check("rsp_quiet",     64'(rsp_valid), 64'(0));
      check("rsp_err_hold",  64'(rsp_err),   64'(hold_err));
      check("rsp_data_hold", 64'(rsp_rdata), 64'(hold_rdata));
    end
  endtask

  task automatic idle_cycle();
    req_valid = 2'b00;
    #1;
    check_rsp();
    check("idle_ready", 64'(req_ready), 64'(0));
    check("idle_sel",   64'({PSEL, PENABLE}), 64'(0));
    check("idle_paddr", 64'(PADDR), 64'(0));
    tick();
  endtask

  task automatic run_xfer(input logic [1:0] v, input logic [1:0] w, input logic [2*AW-1:0] a,
                          input logic [2*DW-1:0] d, input int waits,
                          input logic [DW-1:0] prd, input logic err);
    logic g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; PREADY = 1'b0;
    #1;
    check_rsp();
    g  = v[~m_last] ? ~m_last : m_last;
    ea = a[g*AW +: AW];
    ed = d[g*DW +: DW];
    check("grant_ready", 64'(req_ready), 64'(oh(g)));
    check("idle_psel",   64'(PSEL), 64'(0));
    m_last = g;
    tick();
    req_valid[g] = 1'b0;
    #1;
    check("setup_sel",    64'({PSEL, PENABLE}), 64'(2'b10));
    check("setup_paddr",  64'(PADDR),  64'(ea));
    check("setup_pwrite", 64'(PWRITE), 64'(w[g]));
    check("setup_pwdata", 64'(PWDATA), 64'(ed));
    check("setup_ready",  64'(req_ready), 64'(0));
    tick();
    for (int i = 0; i < waits; i++) begin
      PRDATA = $urandom; PSLVERR = 1'($urandom);
      check("wait_sel",    64'({PSEL, PENABLE}), 64'(2'b11));
      check("wait_paddr",  64'(PADDR),  64'(ea));
      check("wait_pwdata", 64'(PWDATA), 64'(ed));
      tick();
    end
    PREADY = 1'b1; PRDATA = prd; PSLVERR = err;
    check("access_sel",   64'({PSEL, PENABLE}), 64'(2'b11));
    check("access_paddr", 64'(PADDR), 64'(ea));
    tick();
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b0;
    pend = 1'b1; pend_g = g; pend_err = err;
    pend_rdata = w[g] ? '0 : prd;
  endtask

  task automatic model_reset();
    m_last = 1'b1; pend = 1'b0; hold_err = 1'b0; hold_rdata = '0;
  endtask

  initial begin
    logic [1:0] v;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    model_reset();
    PRESETn = 1'b0;
    tick(); tick();
    check("rst_sel",    64'({PSEL, PENABLE, PWRITE}), 64'(0));
    check("rst_paddr",  64'(PADDR), 64'(0));
    check("rst_pwdata", 64'(PWDATA), 64'(0));
    check("rst_rsp",    64'({rsp_valid, rsp_err}), 64'(0));
    check("rst_rdata",  64'(rsp_rdata), 64'(0));
    PRESETn = 1'b1;
    idle_cycle();

    // Req0 write, zero waits
    run_xfer(2'b01, 2'b01, {4'h0, 4'h3}, {32'h0, 32'hDEADBEEF}, 0, 32'h0, 1'b0);
    // Req1 read with slave error
    run_xfer(2'b10, 2'b00, {4'hA, 4'h0}, {32'h0, 32'h0}, 0, 32'h12345678, 1'b1);
    // Both requesting: alternation 0,1,0,1
    for (int k = 0; k < 4; k++)
      run_xfer(2'b11, 2'($urandom), 8'($urandom), {$urandom, $urandom}, 0, $urandom, 1'b0);
    // Three wait states
    run_xfer(2'b01, 2'b11, 8'h5C, {32'h0BAD_F00D, 32'hCAFE_0001}, 3, 32'h0, 1'b0);
    idle_cycle();

    // Reset asserted during ACCESS aborts without a response
    req_valid = 2'b10; req_write = 2'b00; req_addr = 8'h70; PREADY = 1'b0;
    #1; check_rsp(); m_last = 1'b1;
    tick(); req_valid = 2'b00; tick();
    check("pre_abort_sel", 64'({PSEL, PENABLE}), 64'(2'b11));
    PRESETn = 1'b0;
    #1;
    check("abort_sel",   64'({PSEL, PENABLE}), 64'(0));
    check("abort_rsp",   64'(rsp_valid), 64'(0));
    check("abort_paddr", 64'(PADDR), 64'(0));
    tick();
    PRESETn = 1'b1;
    model_reset();
    idle_cycle();
    run_xfer(2'b11, 2'b00, 8'h21, {32'h2, 32'h1}, 0, 32'h5555AAAA, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) idle_cycle();
      v = 2'($urandom_range(1, 3));
      run_xfer(v, 2'($urandom), 8'($urandom), {$urandom, $urandom},
               int'($urandom_range(0, 3)), $urandom, 1'($urandom));
    end
    idle_cycle();

`ifdef APB_TIMEOUT_EN
    // Slave never responds: error response after 16 ACCESS cycles
    req_valid = 2'b01; req_write = 2'b00; req_addr = 8'h09; PREADY = 1'b0;
    #1; check_rsp();
    m_last = ~m_last;
    m_last = req_valid[m_last] ? m_last : ~m_last;
    tick(); req_valid = 2'b00; tick();
    for (int i = 0; i < 16; i++) begin
      check("to_wait_sel", 64'({PSEL, PENABLE}), 64'(2'b11));
      tick();
    end
    pend = 1'b1; pend_g = 1'b0; pend_err = 1'b1; pend_rdata = '0;
    PREADY = 1'b1;
    idle_cycle();
    PREADY = 1'b0;
    idle_cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
